// File: rtl/cache_fill_arbiter_if.sv
// Bundle between the fill arbiter, the two cache miss/fill ports and main memory.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface cache_fill_arbiter_if #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
);
  localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);

  logic              icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [15:0]       mem_data;
  logic [15:0]       fill_data;
  logic [IdxW-1:0]   fill_word;
  logic              fill_we_i;
  logic              fill_we_d;
  logic              tag_we_i;
  logic              tag_we_d;
  logic              fill_done_i;
  logic              fill_done_d;
  logic              busy;

  modport slave (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
    input  mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
    output tag_we_i, tag_we_d, fill_done_i, fill_done_d, busy
  );

  modport master (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
    output mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
    input  tag_we_i, tag_we_d, fill_done_i, fill_done_d, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// I/D-cache miss handler: arbitrates misses, bursts block word reads and steers returns.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN starts each burst at the missing word.
module cache_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_fill_arbiter_if.slave  bus
);
  localparam int unsigned IdxW    = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BlkBits = IdxW + 1;
  localparam int unsigned TagW    = ADDR_W - BlkBits;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e          state_q;
  logic            own_d_q;
  logic [TagW-1:0] tag_q;
  logic [IdxW-1:0] crit_q;
  logic [IdxW-1:0] req_cnt_q;
  logic [IdxW-1:0] req_idx_q;
  logic [IdxW-1:0] rcv_cnt_q;
  logic            mem_en_q;
  logic            done_i_q;
  logic            done_d_q;

  logic            sel_d;
  logic [TagW-1:0] sel_tag;
  logic [IdxW-1:0] sel_crit;
  logic            fill_hit;
  logic            fill_last;

  // D side wins simultaneous misses.
  assign sel_d   = bus.dcache_miss;
  assign sel_tag = sel_d ? bus.dcache_miss_addr[ADDR_W-1:BlkBits]
                         : bus.icache_miss_addr[ADDR_W-1:BlkBits];
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  assign sel_crit = sel_d ? bus.dcache_miss_addr[IdxW:1] : bus.icache_miss_addr[IdxW:1];
`else
  assign sel_crit = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      own_d_q   <= 1'b1;
      tag_q     <= '0;
      crit_q    <= '0;
      req_cnt_q <= '0;
      req_idx_q <= '0;
      rcv_cnt_q <= '0;
      mem_en_q  <= 1'b0;
      done_i_q  <= 1'b0;
      done_d_q  <= 1'b0;
    end else begin
      done_i_q <= 1'b0;
      done_d_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.dcache_miss || bus.icache_miss) begin
            own_d_q   <= sel_d;
            tag_q     <= sel_tag;
            crit_q    <= sel_crit;
            req_idx_q <= sel_crit;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
            mem_en_q  <= 1'b1;
            state_q   <= StFill;
          end
        end
        StFill: begin
          // Request side holds on the last word once the burst is issued.
          if (mem_en_q) begin
            if (req_cnt_q == LastIdx) begin
              mem_en_q <= 1'b0;
            end else begin
              req_cnt_q <= req_cnt_q + 1'b1;
              req_idx_q <= req_idx_q + 1'b1;
            end
          end
          if (bus.mem_data_valid) begin
            rcv_cnt_q <= rcv_cnt_q + 1'b1;
            if (rcv_cnt_q == LastIdx) begin
              state_q  <= StDone;
              done_d_q <= own_d_q;
              done_i_q <= !own_d_q;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Return steering is combinational so each word is written the cycle it arrives.
  assign fill_hit  = (state_q == StFill) && bus.mem_data_valid;
  assign fill_last = fill_hit && (rcv_cnt_q == LastIdx);

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_addr    = {tag_q, req_idx_q, 1'b0};
  assign bus.fill_data   = bus.mem_data;
  assign bus.fill_word   = crit_q + rcv_cnt_q;
  assign bus.fill_we_i   = fill_hit && !own_d_q;
  assign bus.fill_we_d   = fill_hit && own_d_q;
  assign bus.tag_we_i    = fill_last && !own_d_q;
  assign bus.tag_we_d    = fill_last && own_d_q;
  assign bus.fill_done_i = done_i_q;
  assign bus.fill_done_d = done_d_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized scoreboard bench for cache_fill_arbiter with a 4-cycle in-order memory.
module tb_cache_fill_arbiter;
  localparam int unsigned WPB = 8;
  localparam int unsigned AW  = 16;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  typedef struct {
    bit          own_d;
    int          word;
    logic [15:0] data;
    bit          last;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_arbiter_if #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) bus ();

  cache_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [15:0] salt = 16'h0;

  logic [15:0] exp_addr_q[$];
  wr_t         exp_wr_q[$];
  bit          exp_done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  // Memory: fixed 4-cycle latency, in order, not reset with the arbiter.
  logic [3:0]    pv = '0;
  logic [AW-1:0] pa[4];
  logic          stray = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_en};
    pa[0] <= bus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.mem_data_valid = pv[3] | stray;
  assign bus.mem_data       = mem_fn(pa[3]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, value %0h, required none (cycle %0d)", name, act, cyc);
  endtask

  task automatic push_fill(input bit own_d, input logic [15:0] addr);
    logic [15:0] base;
    int          crit;
    int          w;
    wr_t         e;
    base = addr & ~16'(2 * WPB - 1);
    crit = Cwf ? int'((addr >> 1) % 16'(WPB)) : 0;
    for (int n = 0; n < WPB; n++) begin
      w = (crit + n) % WPB;
      exp_addr_q.push_back(base + 16'(2 * w));
      e.own_d = own_d;
      e.word  = w;
      e.data  = mem_fn(base + 16'(2 * w));
      e.last  = (n == WPB - 1);
      exp_wr_q.push_back(e);
    end
    exp_done_q.push_back(own_d);
  endtask

  // Monitor: pops expectations whenever the DUT presents a request, write or done.
  initial begin
    bit  prev_en;
    bit  prev_tag;
    int  run;
    int  gap_due;
    wr_t e;
    bit  d;
    prev_en  = 1'b0;
    prev_tag = 1'b0;
    run      = 0;
    gap_due  = -1;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_en  = 1'b0;
        prev_tag = 1'b0;
        run      = 0;
        gap_due  = -1;
        continue;
      end
      if (bus.mem_en) begin
        if (!prev_en) begin
          run = 0;
          if (gap_due >= 0) begin
            chk("refill_gap", cyc, gap_due);
            gap_due = -1;
          end
        end
        run++;
        if (exp_addr_q.size() == 0) unexpected("mem_req", bus.mem_addr);
        else chk("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
      end else if (prev_en) begin
        chk("req_burst_len", run, WPB);
      end
      prev_en = bus.mem_en;

      if (bus.fill_we_i || bus.fill_we_d || bus.tag_we_i || bus.tag_we_d) begin
        if (exp_wr_q.size() == 0) begin
          unexpected("fill_write", {bus.fill_we_i, bus.fill_we_d, bus.tag_we_i, bus.tag_we_d});
        end else begin
          e = exp_wr_q.pop_front();
          chk("fill_strobes", {bus.fill_we_i, bus.fill_we_d, bus.tag_we_i, bus.tag_we_d},
              {!e.own_d, e.own_d, e.last && !e.own_d, e.last && e.own_d});
          chk("fill_word", bus.fill_word, e.word);
          chk("fill_data", bus.fill_data, e.data);
        end
      end

      if (bus.fill_done_i || bus.fill_done_d) begin
        if (exp_done_q.size() == 0) begin
          unexpected("fill_done", {bus.fill_done_i, bus.fill_done_d});
        end else begin
          d = exp_done_q.pop_front();
          chk("fill_done", {bus.fill_done_i, bus.fill_done_d}, d ? 2'b01 : 2'b10);
        end
        chk("done_after_tag", prev_tag, 1);
        if (exp_addr_q.size() != 0) gap_due = cyc + 2;
      end else if (prev_tag) begin
        unexpected("done_missing", 0);
      end
      prev_tag = bus.tag_we_i || bus.tag_we_d;
    end
  end

  task automatic run_scenario(input bit do_i, input bit do_d, input logic [15:0] ai,
                              input logic [15:0] ad, input int drop_at);
    int n;
    @(negedge clk);
    if (do_d) push_fill(1'b1, ad);
    if (do_i) push_fill(1'b0, ai);
    bus.icache_miss_addr = ai;
    bus.dcache_miss_addr = ad;
    bus.icache_miss      = do_i;
    bus.dcache_miss      = do_d;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (bus.fill_done_d) bus.dcache_miss = 1'b0;
      if (bus.fill_done_i) bus.icache_miss = 1'b0;
      // Flush: the first-served side drops its miss mid-fill.
      if (drop_at > 0 && n == drop_at) begin
        if (do_d) bus.dcache_miss = 1'b0;
        else      bus.icache_miss = 1'b0;
      end
      if (!bus.icache_miss && !bus.dcache_miss && !bus.busy && exp_addr_q.size() == 0 &&
          exp_wr_q.size() == 0 && exp_done_q.size() == 0) break;
    end
    chk("scenario_drain", exp_addr_q.size() + exp_wr_q.size() + exp_done_q.size(), 0);
    chk("scenario_idle", bus.busy, 0);
    bus.icache_miss = 1'b0;
    bus.dcache_miss = 1'b0;
    exp_addr_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr;
    int tags;
    int cnt;
    int r;
    salt                 = 16'($urandom);
    bus.icache_miss      = 1'b0;
    bus.dcache_miss      = 1'b0;
    bus.icache_miss_addr = '0;
    bus.dcache_miss_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.mem_en, bus.fill_we_i, bus.fill_we_d, bus.tag_we_i,
                          bus.tag_we_d, bus.fill_done_i, bus.fill_done_d}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_scenario(1'b0, 1'b1, 16'h0000, 16'h0036, 0);
    run_scenario(1'b1, 1'b1, 16'h1000, 16'h2004, 0);
    run_scenario(1'b0, 1'b1, 16'h0000, 16'h003A, 0);
    run_scenario(1'b1, 1'b0, 16'h0100, 16'h0000, 3);

    // Async reset after three returned words.
    mon_en = 1'b0;
    @(negedge clk);
    bus.dcache_miss_addr = 16'h0452;
    bus.dcache_miss      = 1'b1;
    n    = 0;
    wr   = 0;
    tags = 0;
    while (wr < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.fill_we_d) wr++;
      if (bus.tag_we_i || bus.tag_we_d) tags++;
    end
    chk("rst_prefill_words", wr, 3);
    #2;
    rst_n           = 1'b0;
    bus.dcache_miss = 1'b0;
    #1;
    chk("rst_immediate", {bus.busy, bus.mem_en, bus.fill_we_i, bus.fill_we_d, bus.tag_we_i,
                          bus.tag_we_d}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt   = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.fill_we_i || bus.fill_we_d || bus.fill_done_i || bus.fill_done_d) cnt++;
      if (bus.tag_we_i || bus.tag_we_d) tags++;
    end
    chk("post_rst_writes", cnt, 0);
    chk("rst_no_tag", tags, 0);
    mon_en = 1'b1;

    // Idle with a stuck return valid.
    @(negedge clk);
    stray = 1'b1;
    cnt   = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.fill_we_i || bus.fill_we_d || bus.tag_we_i || bus.tag_we_d ||
          bus.fill_done_i || bus.fill_done_d) cnt++;
    end
    chk("stuck_valid_writes", cnt, 0);
    chk("stuck_valid_busy", bus.busy, 0);
    stray = 1'b0;

    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 2));
      run_scenario(r != 1, r != 0, 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
